bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_countdown_timer.sv | 123 ++++++++++++
 tb/tb_bcd_countdown_timer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Packed-BCD countdown timer with load/start/pause control and a one-cycle done pulse.
// All state advances on the falling edge of clk; reset is synchronous and active-high.
module bcd_countdown_timer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  running,
  output logic                  done,
  output logic                  zero,
  output logic                  preset_err
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_bcd;
  logic [W-1:0]   w_bcd_nxt;
  logic [W-1:0]   w_bcd_dec;
  logic           r_running;
  logic           r_done;
  logic           w_done_nxt;
  logic           r_err;
  logic           w_err_nxt;
  logic           w_preset_ok;

  // Ripple-borrow BCD decrement: a 0 digit wraps to 9 and passes the borrow on.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    w_preset_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (preset[4*i +: 4] > 4'd9) w_preset_ok = 1'b0;
    end
  end

  assign w_bcd_dec = bcd_dec(r_bcd);

  // Next-state: load > pause > start > tick; a request that does not apply falls through.
  always_comb begin
    w_state_nxt = r_state;
    w_bcd_nxt   = r_bcd;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    if (load && (r_state != S_RUN)) begin
      if (w_preset_ok) begin
        w_bcd_nxt   = preset;
        w_state_nxt = S_IDLE;
        w_err_nxt   = 1'b0;
      end else begin
        w_err_nxt   = 1'b1;
      end
    end else if (pause && (r_state == S_RUN)) begin
      w_state_nxt = S_PAUSED;
    end else if (start && ((r_state == S_IDLE) || (r_state == S_PAUSED))) begin
      if (r_bcd != '0) begin
        w_state_nxt = S_RUN;
      end else begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
    end else if (tick && (r_state == S_RUN)) begin
      w_bcd_nxt = w_bcd_dec;
      if (w_bcd_dec == '0) begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bcd     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bcd     <= w_bcd_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bcd        = r_bcd;
  assign running    = r_running;
  assign done       = r_done;
  assign preset_err = r_err;
  assign zero       = (r_bcd == '0);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed table, corner sequences and random traffic
// checked against a decimal-integer reference model.
module tb_bcd_countdown_timer;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic         clk;
  logic         reset;
  logic         tick;
  logic         load;
  logic [W-1:0] preset;
  logic         start;
  logic         pause;
  logic [W-1:0] bcd;
  logic         running;
  logic         done;
  logic         zero;
  logic         preset_err;

  int n_vec;
  int n_bad;

  // Reference model state: count held as a plain decimal integer.
  int m_val;
  int m_st;
  bit m_done;
  bit m_err;

  bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .preset     (preset),
    .start      (start),
    .pause      (pause),
    .bcd        (bcd),
    .running    (running),
    .done       (done),
    .zero       (zero),
    .preset_err (preset_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           x;
    x = v;
    for (int d = 0; d < int'(DIGITS); d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] p);
    int v;
    v = 0;
    for (int d = int'(DIGITS) - 1; d >= 0; d--) v = v * 10 + int'(p[4*d +: 4]);
    return v;
  endfunction

  function automatic bit preset_ok(input logic [W-1:0] p);
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (p[4*d +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    m_done = 1'b0;
    if (reset) begin
      m_val = 0;
      m_st  = M_IDLE;
      m_err = 1'b0;
    end else if (load && m_st != M_RUN) begin
      if (preset_ok(preset)) begin
        m_val = from_bcd(preset);
        m_st  = M_IDLE;
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (pause && m_st == M_RUN) begin
      m_st = M_PAUSED;
    end else if (start && (m_st == M_IDLE || m_st == M_PAUSED)) begin
      if (m_val != 0) m_st = M_RUN;
      else begin
        m_st   = M_DONE;
        m_done = 1'b1;
      end
    end else if (tick && m_st == M_RUN) begin
      m_val = m_val - 1;
      if (m_val == 0) begin
        m_st   = M_DONE;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [W+3:0] act, input logic [W+3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got {bcd,run,done,zero,err}=%h_%b%b%b%b want %h_%b%b%b%b",
               name, $time, act[W+3:4], act[3], act[2], act[1], act[0],
               exp[W+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [W+3:0] dut_vec();
    return {bcd, running, done, zero, preset_err};
  endfunction

  // Drive one cycle's inputs, let the falling edge act, then sample on the rising edge.
  task automatic cycle(input bit rs, input bit ld, input bit st, input bit pa, input bit tk,
                       input logic [W-1:0] pv);
    reset  = rs;
    load   = ld;
    start  = st;
    pause  = pa;
    tick   = tk;
    preset = pv;
    @(negedge clk);
    model_step();
    @(posedge clk);
    check("model", dut_vec(),
          {to_bcd(m_val), (m_st == M_RUN), m_done, (m_val == 0), m_err});
  endtask

  typedef struct {
    bit           rst;
    bit           ld;
    bit           st;
    bit           pa;
    bit           tk;
    logic [W-1:0] pv;
    logic [W-1:0] e_bcd;
    bit           e_run;
    bit           e_done;
    bit           e_err;
  } vec_t;

  vec_t tbl[24];
  int   ndone;
  int   exp_cnt;

  initial begin
    n_vec = 0;
    n_bad = 0;
    m_val = 0;
    m_st  = M_IDLE;
    m_done = 1'b0;
    m_err  = 1'b0;
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0; preset = '0;

    //            rst ld st pa tk preset    exp_bcd   run done err
    tbl[0]  = '{1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 16'h0005, 16'h0005, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 16'h0000, 16'h0005, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 16'h0009, 16'h0005, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0004, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 1, 16'h0009, 16'h0003, 1, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 16'h0009, 16'h0009, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 16'h00A5, 16'h0009, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 0, 16'h0003, 16'h0003, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 1, 16'h0000, 16'h0003, 0, 0, 0};
    tbl[13] = '{0, 0, 1, 0, 1, 16'h0000, 16'h0003, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 0, 16'h0000, 16'h0002, 0, 0, 0};
    tbl[16] = '{0, 1, 0, 0, 0, 16'h1F00, 16'h0002, 0, 0, 1};
    tbl[17] = '{0, 0, 1, 0, 0, 16'h0000, 16'h0002, 1, 0, 1};
    tbl[18] = '{0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 1};
    tbl[19] = '{0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1};
    tbl[20] = '{0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1};
    tbl[21] = '{0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1};
    tbl[22] = '{0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
    tbl[23] = '{0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0};

    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].rst, tbl[i].ld, tbl[i].st, tbl[i].pa, tbl[i].tk, tbl[i].pv);
      check($sformatf("table[%0d]", i), dut_vec(),
            {tbl[i].e_bcd, tbl[i].e_run, tbl[i].e_done, (tbl[i].e_bcd == '0), tbl[i].e_err});
    end

    // Countdown 0102 -> 0000 across both borrow boundaries; one extra tick in DONE.
    cycle(1, 0, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, 0, 16'h0102);
    cycle(0, 0, 1, 0, 0, '0);
    ndone = 0;
    for (int i = 1; i <= 103; i++) begin
      cycle(0, 0, 0, 0, 1, '0);
      exp_cnt = (102 - i < 0) ? 0 : 102 - i;
      check("countdown_bcd", {bcd, 4'b0}, {to_bcd(exp_cnt), 4'b0});
      if (done) ndone++;
      if (i == 102) check("countdown_done_edge", {bcd, running, done, 2'b0}, {16'h0000, 1'b0, 1'b1, 2'b0});
    end
    check("countdown_done_once", {16'(ndone), 4'b0}, {16'd1, 4'b0});

    // Pause together with tick, ticks while paused, then resume.
    cycle(1, 0, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, 0, 16'h0010);
    cycle(0, 0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, '0);
    check("pause_pre", {bcd, running, 3'b0}, {16'h0007, 1'b1, 3'b0});
    cycle(0, 0, 0, 1, 1, '0);
    check("pause_with_tick", {bcd, running, 3'b0}, {16'h0007, 1'b0, 3'b0});
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 1, '0);
      check("paused_hold", {bcd, running, 3'b0}, {16'h0007, 1'b0, 3'b0});
    end
    cycle(0, 0, 1, 0, 0, '0);
    cycle(0, 0, 0, 0, 1, '0);
    check("resume", {bcd, running, 3'b0}, {16'h0006, 1'b1, 3'b0});

    // Reset mid-count with tick held high throughout.
    cycle(0, 1, 0, 1, 1, 16'h9999);
    cycle(0, 1, 0, 0, 1, 16'h9999);
    cycle(0, 0, 1, 0, 1, '0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, '0);
    check("pre_reset", {bcd, running, 3'b0}, {16'h9989, 1'b1, 3'b0});
    cycle(1, 0, 0, 0, 1, '0);
    check("mid_reset", dut_vec(), {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 1, '0);
      check("post_reset_tick", dut_vec(), {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
    end

    // Random traffic against the model; small presets so counts regularly reach zero.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] pv;
      if ($urandom_range(0, 3) != 0) pv = to_bcd(int'($urandom_range(0, 25)));
      else pv = W'($urandom);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 1) == 0), pv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
